// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares one downstream FIFO write port among NUM_REQ producers. A requester is
// granted for up to BURST_MAX beats, stalls on fifo_full, and is acked per beat.
// Build option: define ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration
// (no last_grant state). Default is round-robin starting after the last grant.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_MAX - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t            r_state,    w_state_nxt;
    logic [ID_W-1:0]   r_grant_id, w_grant_nxt;
    logic              r_busy,     w_busy_nxt;
    logic [CNT_W-1:0]  r_beat_cnt, w_cnt_nxt;
`ifndef ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]   r_last_grant, w_last_nxt;
    logic [ID_W-1:0]   w_idx;
`endif

    logic [DATA_W-1:0] w_slot [NUM_REQ];
    logic [ID_W-1:0]   w_winner;
    logic              w_any_req;
    logic              w_req_g;
    logic              w_beat;
    logic              w_last_beat;

    // Unpack the flat request data bus into one beat per requester.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_slot[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Pick the next winner; only consumed while idle.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        w_winner  = '0;
        w_any_req = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
        // Descending scan: the last hit written is the lowest set index.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_winner  = ID_W'(i);
                w_any_req = 1'b1;
            end
        end
`else
        w_idx = '0;
        // Descending scan over offsets: the last hit written is the nearest
        // index after last_grant, wrapping modulo NUM_REQ.
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = ID_W'((int'(r_last_grant) + i) % NUM_REQ);
            if (req[w_idx]) begin
                w_winner  = w_idx;
                w_any_req = 1'b1;
            end
        end
`endif
    end

    // Write-port datapath: a beat moves when the granted requester is valid and the FIFO has room.
    always_comb begin
        w_req_g         = req[r_grant_id];
        w_beat          = (r_state == S_GRANT) && w_req_g && !fifo_full;
        w_last_beat     = (r_beat_cnt == LAST_BEAT);
        fifo_wr_en      = w_beat;
        fifo_data       = w_slot[r_grant_id];
        ack             = '0;
        ack[r_grant_id] = w_beat;
    end

    // Next-state logic: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_beat_cnt;
`ifndef ARB_FIXED_PRIO_EN
        w_last_nxt  = r_last_grant;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_winner;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            S_GRANT: begin
                if (w_beat) begin
                    w_cnt_nxt = w_last_beat ? '0 : r_beat_cnt + 1'b1;
                end
                // Burst exhausted or requester withdrew: any remaining burst is forfeited.
                if ((w_beat && w_last_beat) || !w_req_g) begin
                    w_state_nxt = S_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
`ifndef ARB_FIXED_PRIO_EN
                    w_last_nxt  = r_grant_id;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register; reset is asynchronous so the write port quiesces immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_grant_id   <= '0;
            r_busy       <= 1'b0;
            r_beat_cnt   <= '0;
`ifndef ARB_FIXED_PRIO_EN
            // First search then starts at requester 0.
            r_last_grant <= ID_W'(NUM_REQ - 1);
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_nxt;
            r_busy       <= w_busy_nxt;
            r_beat_cnt   <= w_cnt_nxt;
`ifndef ARB_FIXED_PRIO_EN
            r_last_grant <= w_last_nxt;
`endif
        end
    end

    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Directed scenarios followed by random traffic, every cycle compared against a
// behavioural reference model of the arbiter (grant, burst count, last winner).
// Honours ARB_FIXED_PRIO_EN to match the build of the design under test.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int BURST_MAX = 2;
    localparam int ID_W      = $clog2(NUM_REQ);

    logic                       clk = 1'b0;
    logic                       rstn;
    logic [NUM_REQ-1:0]         req;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         ack;
    logic                       fifo_full;
    logic                       fifo_wr_en;
    logic [DATA_W-1:0]          fifo_data;
    logic [ID_W-1:0]            grant_id;
    logic                       busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model state
    int m_busy;
    int m_grant;
    int m_cnt;
    int m_last;

    // Bookkeeping
    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    int n_busy = 0;
    bit prev_busy;
    bit obs_busy;
    int obs_gid;
    int q_grants[$];
    logic [NUM_REQ-1:0] last_ack;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [NUM_REQ-1:0] r);
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r[k]) return k;
        end
`else
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(m_last + k) % NUM_REQ]) return (m_last + k) % NUM_REQ;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_busy    = 0;
        m_grant   = 0;
        m_cnt     = 0;
        m_last    = NUM_REQ - 1;
        prev_busy = 1'b0;
        last_ack  = '0;
    endtask

    // Entered at a falling edge with inputs set; checks outputs, advances one clock.
    task automatic cycle();
        bit                 exp_beat;
        logic [NUM_REQ-1:0] exp_ack;
        int                 g;
        #2;
        exp_beat = (m_busy != 0) && (req[m_grant] === 1'b1) && !fifo_full;
        exp_ack  = '0;
        if (exp_beat) exp_ack[m_grant] = 1'b1;
        check("busy",       32'(busy),       32'(m_busy));
        check("grant_id",   32'(grant_id),   32'(m_grant));
        check("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_beat));
        check("ack",        32'(ack),        32'(exp_ack));
        check("fifo_data",  32'(fifo_data),  32'(req_data[m_grant*DATA_W +: DATA_W]));
        if (fifo_wr_en === 1'b1) n_wr++;
        if (busy === 1'b1) n_busy++;
        if (busy === 1'b1 && !prev_busy) q_grants.push_back(int'(grant_id));
        prev_busy = (busy === 1'b1);
        obs_busy  = prev_busy;
        obs_gid   = int'(grant_id);
        @(posedge clk);
        if (m_busy == 0) begin
            g = model_pick(req);
            if (g >= 0) begin
                m_grant = g;
                m_busy  = 1;
                m_cnt   = 0;
            end
        end else begin
            if (exp_beat) m_cnt++;
            if (!req[m_grant] || m_cnt == BURST_MAX) begin
                m_busy = 0;
                m_last = m_grant;
                m_cnt  = 0;
            end
        end
        last_ack = exp_ack;
        @(negedge clk);
    endtask

    // Requesters whose beat was just taken present a fresh beat.
    task automatic refresh_acked();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (last_ack[i]) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
    endtask

    // Random traffic obeying the requester contract.
    task automatic rand_drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !last_ack[i]) begin
                if ($urandom_range(7) == 0) req[i] = 1'b0;
            end else begin
                req[i] = ($urandom_range(1) == 1);
                req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
        end
        fifo_full = ($urandom_range(3) == 0);
    endtask

    // Asserts reset from wherever we are, checks outputs drop at once, releases at a falling edge.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_busy",     32'(busy),       32'(0));
        check("rst_wr_en",    32'(fifo_wr_en), 32'(0));
        check("rst_ack",      32'(ack),        32'(0));
        check("rst_grant_id", 32'(grant_id),   32'(0));
        check("rst_data",     32'(fifo_data),  32'(req_data[DATA_W-1:0]));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int w0;
        int b0;
        int n1;
        int n3;
        int exp_order[5];

        rstn      = 1'b1;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single requester, fixed data 0xA5: two beats, one idle cycle, then re-granted.
        req_data[7:0] = 8'hA5;
        req           = 4'b0001;
        w0            = n_wr;
        q_grants.delete();
        repeat (4) cycle();
        check("t1_writes", 32'(n_wr - w0), 32'(2));
        cycle();
        check("t1_regrant_busy", 32'(obs_busy), 32'(1));
        check("t1_regrant_id",   32'(obs_gid),  32'(0));
        check("t1_grants",       32'(q_grants.size()), 32'(2));
        req = '0;
        repeat (2) cycle();

        // All four requesting: rotation and two beats per grant.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        req = 4'b1111;
        w0  = n_wr;
        q_grants.delete();
        repeat (15) begin
            cycle();
            refresh_acked();
        end
`ifdef ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        check("t2_grant_count", 32'(q_grants.size()), 32'(5));
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_order%0d", i),
                  32'((i < q_grants.size()) ? q_grants[i] : -1), 32'(exp_order[i]));
        end
        check("t2_writes", 32'(n_wr - w0), 32'(10));
        req = '0;
        repeat (2) cycle();

        // FIFO full stall on requester 2.
        do_reset();
        req = 4'b0100;
        cycle();
        fifo_full = 1'b1;
        w0 = n_wr;
        b0 = n_busy;
        repeat (4) cycle();
        check("t3_stall_writes", 32'(n_wr - w0),   32'(0));
        check("t3_stall_busy",   32'(n_busy - b0), 32'(4));
        fifo_full = 1'b0;
        w0 = n_wr;
        repeat (2) cycle();
        check("t3_post_writes", 32'(n_wr - w0), 32'(2));
        req = '0;
        cycle();
        check("t3_idle_after", 32'(obs_busy), 32'(0));
        cycle();

        // Early drop by requester 1 after one beat; 2 wins next, 0 skipped.
        do_reset();
        req = 4'b0010;
        cycle();
        req = 4'b0111;
        w0  = n_wr;
        cycle();
        req = 4'b0101;
        cycle();
        check("t4_writes", 32'(n_wr - w0), 32'(1));
        cycle();
        check("t4_idle", 32'(obs_busy), 32'(0));
        cycle();
        check("t4_next_busy", 32'(obs_busy), 32'(1));
`ifdef ARB_FIXED_PRIO_EN
        check("t4_next_id", 32'(obs_gid), 32'(0));
`else
        check("t4_next_id", 32'(obs_gid), 32'(2));
`endif
        req = '0;
        repeat (2) cycle();

        // Asynchronous reset in the middle of a burst.
        req = 4'b0010;
        cycle();
        cycle();
        #2;
        check("t5_busy_before", 32'(busy), 32'(1));
        do_reset();
        req = 4'b1001;
        cycle();
        cycle();
        check("t5_busy_after", 32'(obs_busy), 32'(1));
        check("t5_id_after",   32'(obs_gid),  32'(0));
        req = '0;
        repeat (2) cycle();

        // Requesters 1 and 3 both requesting.
        do_reset();
        req = 4'b1010;
        q_grants.delete();
        repeat (12) begin
            cycle();
            refresh_acked();
        end
        n1 = 0;
        n3 = 0;
        foreach (q_grants[i]) begin
            if (q_grants[i] == 1) n1++;
            if (q_grants[i] == 3) n3++;
        end
`ifdef ARB_FIXED_PRIO_EN
        check("t6_grants_to_1", 32'(n1), 32'(4));
        check("t6_grants_to_3", 32'(n3), 32'(0));
`else
        check("t6_grants_to_1", 32'(n1), 32'(2));
        check("t6_grants_to_3", 32'(n3), 32'(2));
`endif
        req = '0;
        repeat (2) cycle();

        // Random traffic against the model.
        do_reset();
        repeat (400) begin
            rand_drive();
            cycle();
        end
        req       = '0;
        fifo_full = 1'b0;
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
